// File: rtl/btb_assoc.sv
`default_nettype none
// ============================================================================
//  Module   : btb_assoc
//  Purpose  : N-way set-associative branch target buffer with integrated
//             storage, true-LRU replacement and a 2-bit predictor per entry.
//             The IF-stage PC is looked up combinationally from registered
//             storage. Resolved branches from EX train the predictor and
//             allocate entries.
//  Ports    : clk, rst_n                 - clock, synchronous active-low reset
//             rd_en_i, rd_pc_i           - IF lookup (rd_en_i qualifies LRU touch)
//             rd_hit_o, rd_taken_o,
//             rd_target_o                - lookup result (zero on miss)
//             upd_valid_i, upd_pc_i,
//             upd_taken_i, upd_target_i  - resolved branch update
//             flush_i                    - clear all entries (BTB_FLUSH_EN only)
//  Config   : BTB_FLUSH_EN - when defined, flush_i clears every valid bit and
//             resets the LRU ages in one cycle; otherwise flush_i is ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module btb_assoc #(
   parameter int XLEN     = 32,
   parameter int NUM_SETS = 8,
   parameter int NUM_WAYS = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            rd_en_i,
   input  logic [XLEN-1:0] rd_pc_i,
   output logic            rd_hit_o,
   output logic            rd_taken_o,
   output logic [XLEN-1:0] rd_target_o,
   input  logic            upd_valid_i,
   input  logic [XLEN-1:0] upd_pc_i,
   input  logic            upd_taken_i,
   input  logic [XLEN-1:0] upd_target_i,
   input  logic            flush_i
);

   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int AGE_W = $clog2(NUM_WAYS);
   localparam int TAG_W = XLEN - 2 - IDX_W;

   // Predictor encoding is Gray-ordered so prediction is simply state[1].
   localparam logic [1:0] ST_SNT = 2'b00;
   localparam logic [1:0] ST_WNT = 2'b01;
   localparam logic [1:0] ST_WT  = 2'b11;
   localparam logic [1:0] ST_ST  = 2'b10;

   // ---------------------------------------------------------------------
   // Storage
   // ---------------------------------------------------------------------
   logic             valid_q [NUM_SETS][NUM_WAYS];
   logic [TAG_W-1:0] tag_q   [NUM_SETS][NUM_WAYS];
   logic [XLEN-1:0]  tgt_q   [NUM_SETS][NUM_WAYS];
   logic [1:0]       st_q    [NUM_SETS][NUM_WAYS];
   logic [AGE_W-1:0] age_q   [NUM_SETS][NUM_WAYS];

   logic             valid_d [NUM_SETS][NUM_WAYS];
   logic [TAG_W-1:0] tag_d   [NUM_SETS][NUM_WAYS];
   logic [XLEN-1:0]  tgt_d   [NUM_SETS][NUM_WAYS];
   logic [1:0]       st_d    [NUM_SETS][NUM_WAYS];
   logic [AGE_W-1:0] age_d   [NUM_SETS][NUM_WAYS];

   function automatic logic [1:0] st_next(input logic [1:0] st, input logic taken);
      logic [1:0] nxt;
      nxt = st;
      case (st)
         ST_SNT: nxt = taken ? ST_WNT : ST_SNT;
         ST_WNT: nxt = taken ? ST_WT  : ST_SNT;
         ST_WT:  nxt = taken ? ST_ST  : ST_WNT;
         ST_ST:  nxt = taken ? ST_ST  : ST_WT;
         default: nxt = st;
      endcase
      return nxt;
   endfunction

   // ---------------------------------------------------------------------
   // Flush enable (compiled out when the feature is disabled)
   // ---------------------------------------------------------------------
   logic flush_w;
`ifdef BTB_FLUSH_EN
   assign flush_w = flush_i;
`else
   logic unused_flush;
   assign flush_w      = 1'b0;
   assign unused_flush = flush_i;
`endif

   // Byte-offset bits never participate in index or tag.
   logic [3:0] unused_pc_bits;
   assign unused_pc_bits = {rd_pc_i[1:0], upd_pc_i[1:0]};

   // ---------------------------------------------------------------------
   // Read lookup
   // ---------------------------------------------------------------------
   logic [IDX_W-1:0] rd_idx_w;
   logic [TAG_W-1:0] rd_tag_w;
   logic             rd_hit_w;
   logic [AGE_W-1:0] rd_way_w;

   assign rd_idx_w = rd_pc_i[IDX_W+1:2];
   assign rd_tag_w = rd_pc_i[XLEN-1:IDX_W+2];

   always_comb begin
      rd_hit_w = 1'b0;
      rd_way_w = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (valid_q[rd_idx_w][w] && (tag_q[rd_idx_w][w] == rd_tag_w)) begin
            rd_hit_w = 1'b1;
            rd_way_w = AGE_W'(w);
         end
      end
   end

   assign rd_hit_o    = rd_hit_w;
   assign rd_taken_o  = rd_hit_w & st_q[rd_idx_w][rd_way_w][1];
   assign rd_target_o = rd_hit_w ? tgt_q[rd_idx_w][rd_way_w] : '0;

   // ---------------------------------------------------------------------
   // Update lookup and victim selection
   // ---------------------------------------------------------------------
   logic [IDX_W-1:0] upd_idx_w;
   logic [TAG_W-1:0] upd_tag_w;
   logic             upd_hit_w;
   logic [AGE_W-1:0] upd_hit_way_w;
   logic             inv_found_w;
   logic [AGE_W-1:0] inv_way_w;
   logic [AGE_W-1:0] lru_way_w;
   logic [AGE_W-1:0] upd_way_w;
   logic             upd_wr_w;
   logic             rd_touch_w;

   assign upd_idx_w = upd_pc_i[IDX_W+1:2];
   assign upd_tag_w = upd_pc_i[XLEN-1:IDX_W+2];

   always_comb begin
      upd_hit_w     = 1'b0;
      upd_hit_way_w = '0;
      inv_found_w   = 1'b0;
      inv_way_w     = '0;
      lru_way_w     = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (valid_q[upd_idx_w][w] && (tag_q[upd_idx_w][w] == upd_tag_w)) begin
            upd_hit_w     = 1'b1;
            upd_hit_way_w = AGE_W'(w);
         end
         if (age_q[upd_idx_w][w] == AGE_W'(NUM_WAYS - 1)) begin
            lru_way_w = AGE_W'(w);
         end
      end
      // Scan downward so the lowest-index invalid way wins.
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (!valid_q[upd_idx_w][w]) begin
            inv_found_w = 1'b1;
            inv_way_w   = AGE_W'(w);
         end
      end
   end

   assign upd_way_w = upd_hit_w   ? upd_hit_way_w :
                      inv_found_w ? inv_way_w     : lru_way_w;

   // Not-taken misses neither allocate nor age the set.
   assign upd_wr_w   = upd_valid_i && (upd_hit_w || upd_taken_i);

   // A read touch yields to any update aimed at the same set.
   assign rd_touch_w = rd_en_i && rd_hit_w &&
                       !(upd_valid_i && (upd_idx_w == rd_idx_w));

   // ---------------------------------------------------------------------
   // Next-state
   // ---------------------------------------------------------------------
   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      tgt_d   = tgt_q;
      st_d    = st_q;
      age_d   = age_q;
      if (flush_w) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
               valid_d[s][w] = 1'b0;
               age_d[s][w]   = AGE_W'(w);
            end
         end
      end else begin
         if (upd_wr_w) begin
            valid_d[upd_idx_w][upd_way_w] = 1'b1;
            tag_d[upd_idx_w][upd_way_w]   = upd_tag_w;
            if (upd_taken_i) begin
               tgt_d[upd_idx_w][upd_way_w] = upd_target_i;
            end
            st_d[upd_idx_w][upd_way_w] = upd_hit_w ?
               st_next(st_q[upd_idx_w][upd_way_w], upd_taken_i) : ST_WT;
            for (int w = 0; w < NUM_WAYS; w++) begin
               if (AGE_W'(w) == upd_way_w) begin
                  age_d[upd_idx_w][w] = '0;
               end else if (age_q[upd_idx_w][w] < age_q[upd_idx_w][upd_way_w]) begin
                  age_d[upd_idx_w][w] = age_q[upd_idx_w][w] + AGE_W'(1);
               end
            end
         end
         // Never the same set as the update touch, so no write conflict.
         if (rd_touch_w) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
               if (AGE_W'(w) == rd_way_w) begin
                  age_d[rd_idx_w][w] = '0;
               end else if (age_q[rd_idx_w][w] < age_q[rd_idx_w][rd_way_w]) begin
                  age_d[rd_idx_w][w] = age_q[rd_idx_w][w] + AGE_W'(1);
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
               valid_q[s][w] <= 1'b0;
               tag_q[s][w]   <= '0;
               tgt_q[s][w]   <= '0;
               st_q[s][w]    <= ST_WNT;
               age_q[s][w]   <= AGE_W'(w);
            end
         end
      end else begin
         valid_q <= valid_d;
         tag_q   <= tag_d;
         tgt_q   <= tgt_d;
         st_q    <= st_d;
         age_q   <= age_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_btb_assoc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_btb_assoc
//  Purpose  : Self-checking bench for btb_assoc (XLEN=32, 8 sets, 2 ways).
//             Expected lookup results are queued as each read is driven and
//             popped when the combinational result is sampled.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_btb_assoc;

   typedef struct packed {
      logic        hit;
      logic        taken;
      logic [31:0] tgt;
   } rd_exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rd_en = 1'b0;
   logic [31:0] rd_pc = '0;
   logic        rd_hit;
   logic        rd_taken;
   logic [31:0] rd_target;
   logic        upd_valid = 1'b0;
   logic [31:0] upd_pc = '0;
   logic        upd_taken = 1'b0;
   logic [31:0] upd_target = '0;
   logic        flush = 1'b0;

   int errors = 0;
   int checks = 0;
   rd_exp_t sb[$];

   btb_assoc #(.XLEN(32), .NUM_SETS(8), .NUM_WAYS(2)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rd_en_i      (rd_en),
      .rd_pc_i      (rd_pc),
      .rd_hit_o     (rd_hit),
      .rd_taken_o   (rd_taken),
      .rd_target_o  (rd_target),
      .upd_valid_i  (upd_valid),
      .upd_pc_i     (upd_pc),
      .upd_taken_i  (upd_taken),
      .upd_target_i (upd_target),
      .flush_i      (flush)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic rd_exp_t mk(input logic h, input logic t, input logic [31:0] g);
      rd_exp_t e;
      e.hit = h; e.taken = t; e.tgt = g;
      return e;
   endfunction

   // Drive a lookup PC and queue what it must return.
   task automatic rd_push(input logic [31:0] pc, input rd_exp_t e);
      rd_pc = pc;
      sb.push_back(e);
   endtask

   // One-cycle update; returns 1 ns after the capturing edge.
   task automatic do_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
      upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tg;
      @(posedge clk); #1;
      upd_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; rd_en = 1'b0; upd_valid = 1'b0; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rd_exp_t got, exp;
      do_reset();
      rd_push(32'h100, mk(1'b0, 1'b0, 32'h0));
      #1; got = {rd_hit, rd_taken, rd_target}; exp = sb.pop_front(); checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL reset: got %b/%b/%h want %b/%b/%h", got.hit, got.taken, got.tgt, exp.hit, exp.taken, exp.tgt);
      end
   endtask

   task automatic test_alloc_hit();
      rd_exp_t got, exp;
      logic [31:0] pcs [3];
      rd_exp_t want [3];
      do_upd(32'h100, 1'b1, 32'h200);
      pcs[0] = 32'h100; want[0] = mk(1'b1, 1'b1, 32'h200);
      pcs[1] = 32'h104; want[1] = mk(1'b0, 1'b0, 32'h0);   // other set
      pcs[2] = 32'h900; want[2] = mk(1'b0, 1'b0, 32'h0);   // same set, other tag
      for (int i = 0; i < 3; i++) begin
         rd_push(pcs[i], want[i]);
         #1; got = {rd_hit, rd_taken, rd_target}; exp = sb.pop_front(); checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL alloc_hit[%0d]: got %b/%b/%h want %b/%b/%h", i, got.hit, got.taken, got.tgt, exp.hit, exp.taken, exp.tgt);
         end
      end
   endtask

   // Walks the counter through every transition from weak-T (11).
   task automatic test_predictor();
      rd_exp_t got, exp;
      logic        tk  [9];
      logic [31:0] tg  [9];
      logic        wt  [9];
      logic [31:0] wg  [9];
      tk = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      tg = '{32'h999, 32'h999, 32'h999, 32'h200, 32'h200, 32'h204, 32'h204, 32'h888, 32'h888};
      wt = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      wg = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h200, 32'h204, 32'h204, 32'h204, 32'h204};
      for (int i = 0; i < 9; i++) begin
         do_upd(32'h100, tk[i], tg[i]);
         rd_push(32'h100, mk(1'b1, wt[i], wg[i]));
         #1; got = {rd_hit, rd_taken, rd_target}; exp = sb.pop_front(); checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL predictor[%0d]: got %b/%b/%h want %b/%b/%h", i, got.hit, got.taken, got.tgt, exp.hit, exp.taken, exp.tgt);
         end
      end
   endtask

   // Fill set 0, touch 0x100 by a read, then evict the LRU way.
   task automatic test_set_fill();
      rd_exp_t got, exp;
      logic [31:0] pcs [3];
      rd_exp_t want [3];
      do_reset();
      do_upd(32'h100, 1'b1, 32'h1100);
      do_upd(32'h120, 1'b1, 32'h1120);
      rd_pc = 32'h100; rd_en = 1'b1;
      @(posedge clk); #1;
      rd_en = 1'b0;
      do_upd(32'h140, 1'b1, 32'h1140);
      pcs[0] = 32'h120; want[0] = mk(1'b0, 1'b0, 32'h0);
      pcs[1] = 32'h100; want[1] = mk(1'b1, 1'b1, 32'h1100);
      pcs[2] = 32'h140; want[2] = mk(1'b1, 1'b1, 32'h1140);
      for (int i = 0; i < 3; i++) begin
         rd_push(pcs[i], want[i]);
         #1; got = {rd_hit, rd_taken, rd_target}; exp = sb.pop_front(); checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL set_fill[%0d]: got %b/%b/%h want %b/%b/%h", i, got.hit, got.taken, got.tgt, exp.hit, exp.taken, exp.tgt);
         end
      end
   endtask

   // Not-taken miss allocates nothing; a read touch colliding with an
   // update to the same set is dropped, so 0x100 stays the victim.
   task automatic test_nt_miss_conflict();
      rd_exp_t got, exp;
      logic [31:0] pcs [3];
      rd_exp_t want [3];
      do_upd(32'h160, 1'b0, 32'h1160);
      rd_push(32'h160, mk(1'b0, 1'b0, 32'h0));
      #1; got = {rd_hit, rd_taken, rd_target}; exp = sb.pop_front(); checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL nt_miss: got %b/%b/%h want %b/%b/%h", got.hit, got.taken, got.tgt, exp.hit, exp.taken, exp.tgt);
      end
      rd_pc = 32'h100; rd_en = 1'b1;
      do_upd(32'h160, 1'b0, 32'h1160);
      rd_en = 1'b0;
      do_upd(32'h180, 1'b1, 32'h1180);
      pcs[0] = 32'h100; want[0] = mk(1'b0, 1'b0, 32'h0);
      pcs[1] = 32'h140; want[1] = mk(1'b1, 1'b1, 32'h1140);
      pcs[2] = 32'h180; want[2] = mk(1'b1, 1'b1, 32'h1180);
      for (int i = 0; i < 3; i++) begin
         rd_push(pcs[i], want[i]);
         #1; got = {rd_hit, rd_taken, rd_target}; exp = sb.pop_front(); checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL conflict[%0d]: got %b/%b/%h want %b/%b/%h", i, got.hit, got.taken, got.tgt, exp.hit, exp.taken, exp.tgt);
         end
      end
   endtask

   // Same-cycle update and read: old contents now, new contents next cycle.
   task automatic test_back_to_back();
      rd_exp_t got, exp;
      upd_valid = 1'b1; upd_pc = 32'h140; upd_taken = 1'b1; upd_target = 32'h2140;
      rd_push(32'h140, mk(1'b1, 1'b1, 32'h1140));
      #1; got = {rd_hit, rd_taken, rd_target}; exp = sb.pop_front(); checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL no_bypass_old: got %b/%b/%h want %b/%b/%h", got.hit, got.taken, got.tgt, exp.hit, exp.taken, exp.tgt);
      end
      @(posedge clk); #1;
      upd_valid = 1'b0;
      rd_push(32'h140, mk(1'b1, 1'b1, 32'h2140));
      #1; got = {rd_hit, rd_taken, rd_target}; exp = sb.pop_front(); checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL no_bypass_new: got %b/%b/%h want %b/%b/%h", got.hit, got.taken, got.tgt, exp.hit, exp.taken, exp.tgt);
      end
   endtask

   // Set 0 now holds 0x180 (way0, LRU) and 0x140 (way1, MRU).
   task automatic test_flush();
      rd_exp_t got, exp;
      logic [31:0] pcs [3];
      rd_exp_t want [3];
      flush = 1'b1;
      upd_valid = 1'b1; upd_pc = 32'h1A0; upd_taken = 1'b1; upd_target = 32'h11A0;
      rd_push(32'h140, mk(1'b1, 1'b1, 32'h2140));
      #1; got = {rd_hit, rd_taken, rd_target}; exp = sb.pop_front(); checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL flush_cycle_read: got %b/%b/%h want %b/%b/%h", got.hit, got.taken, got.tgt, exp.hit, exp.taken, exp.tgt);
      end
      @(posedge clk); #1;
      flush = 1'b0; upd_valid = 1'b0;
`ifdef BTB_FLUSH_EN
      pcs[0] = 32'h1A0; want[0] = mk(1'b0, 1'b0, 32'h0);
      pcs[1] = 32'h140; want[1] = mk(1'b0, 1'b0, 32'h0);
      pcs[2] = 32'h180; want[2] = mk(1'b0, 1'b0, 32'h0);
`else
      pcs[0] = 32'h1A0; want[0] = mk(1'b1, 1'b1, 32'h11A0);
      pcs[1] = 32'h140; want[1] = mk(1'b1, 1'b1, 32'h2140);
      pcs[2] = 32'h180; want[2] = mk(1'b0, 1'b0, 32'h0);
`endif
      for (int i = 0; i < 3; i++) begin
         rd_push(pcs[i], want[i]);
         #1; got = {rd_hit, rd_taken, rd_target}; exp = sb.pop_front(); checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL flush[%0d]: got %b/%b/%h want %b/%b/%h", i, got.hit, got.taken, got.tgt, exp.hit, exp.taken, exp.tgt);
         end
      end
   endtask

   // Reset asserted alongside an update: the update is discarded.
   task automatic test_reset_mid();
      rd_exp_t got, exp;
      logic [31:0] pcs [3];
      do_upd(32'h1E0, 1'b1, 32'h11E0);
      rd_push(32'h1E0, mk(1'b1, 1'b1, 32'h11E0));
      #1; got = {rd_hit, rd_taken, rd_target}; exp = sb.pop_front(); checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL pre_reset: got %b/%b/%h want %b/%b/%h", got.hit, got.taken, got.tgt, exp.hit, exp.taken, exp.tgt);
      end
      rst_n = 1'b0;
      do_upd(32'h1C0, 1'b1, 32'h11C0);
      rst_n = 1'b1;
      pcs = '{32'h1E0, 32'h1C0, 32'h140};
      for (int i = 0; i < 3; i++) begin
         rd_push(pcs[i], mk(1'b0, 1'b0, 32'h0));
         #1; got = {rd_hit, rd_taken, rd_target}; exp = sb.pop_front(); checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL reset_mid[%0d]: got %b/%b/%h want %b/%b/%h", i, got.hit, got.taken, got.tgt, exp.hit, exp.taken, exp.tgt);
         end
      end
   endtask

   initial begin
      test_reset();
      test_alloc_hit();
      test_predictor();
      test_set_fill();
      test_nt_miss_conflict();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
